event_snapshot_capture: RTL and testbench
=========================================

// Module: event_snapshot_capture
// PURPOSE
//  Upstream event stage for the UFM event-save path. Synchronises EVT_BIT raw event lines and
//  detects any change against the last committed snapshot. Waits a tick-based settle window,
//  then presents one stable EVT_BIT-wide snapshot with a valid/ack handshake.
//  The downstream ufm_rw256_top consumes the snapshot on its gpi input and persists it to UFM.
// PARAMETERS
//  EVT_BIT        256  width of event vector / snapshot
//  HOLDOFF_TICKS  10   settle window in tick_i pulses (0 = commit on cycle after detect)
//  CNT_W          16   width of committed-snapshot counter
// PORTS
//  clk_i        in   1        system clock (OSCH domain)
//  rst_i        in   1        reset, asynchronous, active-high
//  tick_i       in   1        1-cycle timebase pulse (TimerMang Trigger1ms)
//  evt_i        in   EVT_BIT  raw asynchronous event lines
//  snap_o       out  EVT_BIT  committed snapshot, stable while snap_valid_o=1
//  snap_valid_o out  1        snapshot pending for downstream
//  snap_ack_i   in   1        downstream accepted snapshot (sampled only while snap_valid_o=1)
//  clr_ovf_i    in   1        clears ovf_o
//  busy_o       out  1        high in HOLDOFF or PEND
//  ovf_o        out  1        sticky: change lost while snapshot pending
//  evt_cnt_o    out  CNT_W    number of committed snapshots, saturating
// BEHAVIOUR
//  Reset: snap_o=0, ref=0, snap_valid_o=0, busy_o=0, ovf_o=0, evt_cnt_o=0, state IDLE, hold_cnt=0.
//  Sync: 2-flop per bit; evt_s = evt_i delayed 2 clk. Detect: chg = (evt_s != ref).
//  FSM:
//   IDLE    chg -> HOLDOFF, hold_cnt=0 (if HOLDOFF_TICKS=0 go direct to COMMIT).
//   HOLDOFF if evt_s differs from its value one clk earlier: hold_cnt=0 (window restarts).
//           else on tick_i: hold_cnt++. When hold_cnt==HOLDOFF_TICKS -> COMMIT.
//           If evt_s returns to ref before commit -> IDLE, no snapshot, no count.
//   COMMIT  (1 clk) snap_o<=evt_s, ref<=evt_s, evt_cnt_o++ (hold at all-ones), -> PEND.
//   PEND    snap_valid_o=1; snap_ack_i=1 -> snap_valid_o=0 next clk -> IDLE.
//           Any change of evt_s vs ref while in PEND sets ovf_o=1. Later changes are not lost:
//           they are caught by chg when the FSM returns to IDLE.
//  Ack seen with snap_valid_o=0 is ignored. clr_ovf_i and a set condition in the same clk: set wins.
//  Latency: stable change to snap_valid_o = 2 (sync) + 1 (detect) + window + 1 (commit) clk.
//  evt_s captured into snap_o exactly once per commit; snap_o never changes while valid.
//  rst_i mid-operation: immediate return to reset values; a pending snapshot is dropped.
// CONFIGURATION
//  EVT_TIMESTAMP_EN defined: adds output ts_o [31:0] with reset value 0.
//   A free-running counter increments on each tick_i and wraps 0xFFFFFFFF->0.
//   ts_o latches that counter in COMMIT and is stable while snap_valid_o=1.
//  Not defined: no counter, no ts_o port.
// STRUCTURE
//  Package event_capture_pkg holds:
//   - state typedef {IDLE, HOLDOFF, COMMIT, PEND}
//   - default constants EVT_BIT_DEF=256, HOLDOFF_DEF=10, TS_W=32.
//  Sub-module evt_sync: parameterised WIDTH-bit 2-flop synchroniser with async active-high reset.
//  FSM, hold counter, ref/snap registers and counters live in this module.
// TESTING
//  1. Reset, evt_i=0 for 50 ticks -> snap_valid_o stays 0, evt_cnt_o=0.
//  2. evt_i[3]=1 held -> after 10 ticks snap_valid_o=1, snap_o=0x...08, evt_cnt_o=1.
//     Ack -> valid drops next clk.
//  3. evt_i[7] pulsed high for 3 ticks then low -> no snapshot, evt_cnt_o unchanged, busy_o back to 0.
//  4. In PEND, no ack, toggle evt_i[200] -> ovf_o=1, snap_o unchanged.
//     Ack -> second snapshot includes bit 200; clr_ovf_i -> ovf_o=0.
//  5. evt_i[0] toggles every 5 ticks for 40 ticks, then holds -> exactly one commit,
//     10 ticks after the last toggle.
//  6. Assert rst_i while snap_valid_o=1 -> all outputs 0 in the same cycle.
//     With EVT_TIMESTAMP_EN: a commit 25 ticks after reset gives ts_o=25 (+/-1).

Source files
------------

// File: rtl/event_capture_pkg.sv
// Shared types and default constants for the event snapshot capture block.
package event_capture_pkg;

    localparam int unsigned EVT_BIT_DEF = 256;
    localparam int unsigned HOLDOFF_DEF = 10;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned TS_W        = 32;

    // Capture FSM: wait for a change, let it settle, commit once, hold until acknowledged.
    typedef enum logic [1:0] {
        StIdle,
        StHoldoff,
        StCommit,
        StPend
    } state_e;

    // Width needed to hold values 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/evt_sync.sv
// WIDTH-bit two-flop synchroniser for asynchronous event lines.
// Each bit is synchronised independently; no multi-bit coherency is implied.
module evt_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/event_snapshot_capture.sv
// Event snapshot capture: synchronises raw event lines, waits for them to settle for a
// tick-based window after any change, then presents one stable snapshot under a
// valid/ack handshake. Changes arriving while a snapshot is pending set a sticky
// overflow flag and are picked up again once the pending snapshot is acknowledged.
// Optional feature: define EVT_TIMESTAMP_EN to add ts_o, the tick count at commit time.
module event_snapshot_capture
    import event_capture_pkg::*;
#(
    parameter int unsigned EVT_BIT       = EVT_BIT_DEF,
    parameter int unsigned HOLDOFF_TICKS = HOLDOFF_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_i,
    input  logic [EVT_BIT-1:0] evt_i,
    output logic [EVT_BIT-1:0] snap_o,
    output logic               snap_valid_o,
    input  logic               snap_ack_i,
    input  logic               clr_ovf_i,
    output logic               busy_o,
    output logic               ovf_o,
    output logic [CNT_W-1:0]   evt_cnt_o
`ifdef EVT_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]    ts_o
`endif
);

    localparam int unsigned        HOLD_W   = cnt_width(HOLDOFF_TICKS);
    localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(HOLDOFF_TICKS);

    state_e             state_q;
    state_e             state_d;
    logic [EVT_BIT-1:0] evt_s;
    logic [EVT_BIT-1:0] evt_prev_q;
    logic [EVT_BIT-1:0] ref_q;
    logic [EVT_BIT-1:0] snap_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [CNT_W-1:0]   evt_cnt_q;
    logic               ovf_q;
    logic               chg;
    logic               restart;
    logic               ovf_set;

    evt_sync #(
        .WIDTH (EVT_BIT)
    ) u_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (evt_i),
        .dout (evt_s)
    );

    // Difference against the last committed snapshot, and against the previous cycle.
    assign chg     = (evt_s != ref_q);
    assign restart = (evt_s != evt_prev_q);
    assign ovf_set = (state_q == StPend) && chg;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a return to the committed value abandons the window silently.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (chg) begin
                    state_d = (HOLDOFF_TICKS == 0) ? StCommit : StHoldoff;
                end
            end
            StHoldoff: begin
                if (!chg) begin
                    state_d = StIdle;
                end else if (!restart && (hold_q == HOLD_MAX)) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d = StPend;
            end
            StPend: begin
                if (snap_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state and registers only, so they are glitch-free.
    always_comb begin
        snap_valid_o = (state_q == StPend);
        busy_o       = (state_q == StHoldoff) || (state_q == StPend);
        snap_o       = snap_q;
        ovf_o        = ovf_q;
        evt_cnt_o    = evt_cnt_q;
    end

    // One-cycle-delayed copy of the synchronised lines for settle-window restarts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_prev_q <= '0;
        end else begin
            evt_prev_q <= evt_s;
        end
    end

    // Settle-window tick counter; any movement of the lines restarts the window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else if (state_q != StHoldoff) begin
            hold_q <= '0;
        end else if (restart) begin
            hold_q <= '0;
        end else if (tick_i && (hold_q != HOLD_MAX)) begin
            hold_q <= hold_q + 1'b1;
        end
    end

    // Commit: snapshot and reference are loaded together so snap_o always equals ref.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            snap_q <= '0;
            ref_q  <= '0;
        end else if (state_q == StCommit) begin
            snap_q <= evt_s;
            ref_q  <= evt_s;
        end
    end

    // Committed-snapshot counter, saturating at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_cnt_q <= '0;
        end else if ((state_q == StCommit) && (evt_cnt_q != '1)) begin
            evt_cnt_q <= evt_cnt_q + 1'b1;
        end
    end

    // Sticky overflow; a new loss in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf_i) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ts_q;

    // Free-running tick counter, wraps naturally at the top of its range.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_cnt_q <= '0;
        end else if (tick_i) begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
        end
    end

    // Timestamp latched alongside the snapshot so both stay stable while valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q <= '0;
        end else if (state_q == StCommit) begin
            ts_q <= ts_cnt_q;
        end
    end

    assign ts_o = ts_q;
`endif

endmodule

// File: tb/tb_event_snapshot_capture.sv
// Self-checking bench for event_snapshot_capture: a behavioural model tracks how many
// ticks the synchronised lines have stayed quiet, and the DUT is compared against it
// every cycle, alongside hand-computed expectations for the directed scenarios.
module tb_event_snapshot_capture;
    import event_capture_pkg::*;

    localparam int unsigned W    = 256;
    localparam int unsigned HOLD = 10;
    localparam int unsigned CW   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick = 1'b0;
    logic [W-1:0]  evt = '0;
    logic          ack = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  snap;
    logic          valid;
    logic          busy;
    logic          ovf;
    logic [CW-1:0] cnt;
`ifdef EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif

    int n_checks   = 0;
    int n_fail     = 0;
    int tick_total = 0;

    event_snapshot_capture #(
        .EVT_BIT       (W),
        .HOLDOFF_TICKS (HOLD),
        .CNT_W         (CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tick_i       (tick),
        .evt_i        (evt),
        .snap_o       (snap),
        .snap_valid_o (valid),
        .snap_ack_i   (ack),
        .clr_ovf_i    (clr),
        .busy_o       (busy),
        .ovf_o        (ovf),
        .evt_cnt_o    (cnt)
`ifdef EVT_TIMESTAMP_EN
        ,
        .ts_o         (ts)
`endif
    );

    always #5 clk = ~clk;

    // Tick every fourth cycle, driven on the falling edge.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div++;
            tick = (div % 4 == 0);
        end
    end

    always @(posedge clk) if (tick) tick_total++;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // quiet = ticks the lines have stayed unchanged while differing from the last
    // commit (-1 when nothing is being watched).
    logic [W-1:0]  m_p1 = '0, m_p2 = '0, m_prev = '0, m_ref = '0, m_snap = '0;
    int            m_quiet = -1;
    bit            m_commit = 1'b0, m_valid = 1'b0, m_ovf = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    logic [31:0]   m_tsc = '0, m_ts = '0;

    always @(posedge clk or posedge rst) begin
        logic [W-1:0] es;
        bit lost;
        if (rst) begin
            m_p1 = '0; m_p2 = '0; m_prev = '0; m_ref = '0; m_snap = '0;
            m_quiet = -1; m_commit = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
            m_cnt = '0; m_tsc = '0; m_ts = '0;
        end else begin
            es   = m_p2;
            lost = 1'b0;
            if (m_valid) begin
                lost = (es != m_ref);
                if (ack) m_valid = 1'b0;
            end else if (m_commit) begin
                m_snap   = es;
                m_ref    = es;
                m_ts     = m_tsc;
                m_commit = 1'b0;
                m_valid  = 1'b1;
                if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
            end else if (m_quiet >= 0) begin
                if (es == m_ref) m_quiet = -1;
                else if (es != m_prev) m_quiet = 0;
                else if (m_quiet == HOLD) begin m_quiet = -1; m_commit = 1'b1; end
                else if (tick) m_quiet++;
            end else if (es != m_ref) begin
                if (HOLD == 0) m_commit = 1'b1;
                else m_quiet = 0;
            end
            if (lost) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            m_prev = es;
            m_p2   = m_p1;
            m_p1   = evt;
            if (tick) m_tsc = m_tsc + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("snap_o", snap, m_snap);
        chk("snap_valid_o", valid, m_valid);
        chk("busy_o", busy, (m_quiet >= 0) || m_valid);
        chk("ovf_o", ovf, m_ovf);
        chk("evt_cnt_o", cnt, m_cnt);
`ifdef EVT_TIMESTAMP_EN
        chk("ts_o", ts, m_ts);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_valid(input string nm, input int max_cyc);
        int c;
        c = 0;
        while (valid !== 1'b1 && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: snap_valid_o is %b after %0d cycles, want 1", nm, valid, max_cyc);
        end
    endtask

    task automatic chk_latency(input string nm, input int t0);
        int lat;
        lat = tick_total - t0;
        n_checks++;
        if (lat < HOLD || lat > HOLD + 1) begin
            n_fail++;
            $display("FAIL %s: valid after %0d ticks, want %0d..%0d", nm, lat, HOLD, HOLD + 1);
        end
    endtask

    task automatic do_ack(input string nm);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk(nm, valid, 0);
    endtask

    initial begin
        int           t0;
        logic [W-1:0] e;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_valid", valid, 0);
        chk("reset_snap", snap, 0);
        chk("reset_cnt", cnt, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", ovf, 0);
        rst = 1'b0;

        // 1: quiet lines for 50 ticks
        repeat (200) @(negedge clk);
        chk("quiet_valid", valid, 0);
        chk("quiet_cnt", cnt, 0);

        // 2: single held event
        evt[3] = 1'b1;
        t0 = tick_total;
        wait_valid("single_wait", 100);
        chk_latency("single_latency", t0);
        chk("single_snap", snap, 256'h8);
        chk("single_cnt", cnt, 1);
        do_ack("single_ack_drop");

        // 3: glitch shorter than the window
        evt[7] = 1'b1;
        repeat (12) @(negedge clk);
        evt[7] = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_cnt", cnt, 1);
        chk("glitch_busy", busy, 0);
        chk("glitch_valid", valid, 0);

        // 4: overflow while pending, then re-capture
        evt[9] = 1'b1;
        wait_valid("ovf_wait1", 100);
        e = '0; e[3] = 1'b1; e[9] = 1'b1;
        chk("ovf_snap1", snap, e);
        chk("ovf_cnt1", cnt, 2);
        evt[200] = 1'b1;
        repeat (6) @(negedge clk);
        chk("ovf_set", ovf, 1);
        chk("ovf_snap_stable", snap, e);
        do_ack("ovf_ack1");
        wait_valid("ovf_wait2", 100);
        e[200] = 1'b1;
        chk("ovf_snap2", snap, e);
        chk("ovf_cnt2", cnt, 3);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ovf_clear", ovf, 0);
        do_ack("ovf_ack2");

        // 5: bouncing line, nine toggles five ticks apart, then held
        for (int k = 0; k < 9; k++) begin
            evt[0] = ~evt[0];
            t0 = tick_total;
            if (k < 8) repeat (20) @(negedge clk);
        end
        wait_valid("bounce_wait", 100);
        chk_latency("bounce_latency", t0);
        chk("bounce_cnt", cnt, 4);
        e[0] = 1'b1;
        chk("bounce_snap", snap, e);
        do_ack("bounce_ack");

        // 6: reset while a snapshot is pending
        evt[1] = 1'b1;
        wait_valid("rst_wait", 100);
        chk("rst_cnt_before", cnt, 5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_snap", snap, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
`ifdef EVT_TIMESTAMP_EN
        chk("rst_ts", ts, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        e[1] = 1'b1;
        chk("post_rst_cnt", cnt, 1);
        chk("post_rst_snap", snap, e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
